// File: rtl/ras_checkpointed.sv
// ras_checkpointed: return address stack for the fetch stage with per-branch
// checkpoints. The stack state is saved when a speculative branch is fetched,
// and restored from the oldest outstanding checkpoint on a misprediction flush.
//
// Optional feature macro: RAS_TOS_REPAIR_EN
//   When defined, each checkpoint also saves the top-of-stack entry. A restore
//   writes that entry back, so a wrong-path push that overwrote it is undone.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset (stack memory is not cleared)
//   fetch_flush    misprediction flush; restore from oldest checkpoint
//   early_flush    early branch flush; discard checkpoints, no restore
//   branch_fetched speculative branch fetched; take checkpoint
//   branch_retired oldest branch resolved; release its checkpoint
//   push           call fetched; push new_addr
//   pop            return fetched; pop top of stack
//   new_addr       return address to push
//   addr           current top-of-stack prediction (mem[read_index])
//   addr_valid     stack non-empty
//   ckpt_full      checkpoint store holds CKPT_DEPTH entries
module ras_checkpointed #(
  parameter int RAS_ENTRIES = 8,
  parameter int ADDR_W      = 32,
  parameter int CKPT_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_flush,
  input  logic              early_flush,
  input  logic              branch_fetched,
  input  logic              branch_retired,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] new_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              ckpt_full
);

  localparam int RAS_DEPTH_W = $clog2(RAS_ENTRIES);
  localparam int CNT_W       = $clog2(RAS_ENTRIES + 1);
  localparam int CK_PTR_W    = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1;
  localparam int CK_NUM_W    = $clog2(CKPT_DEPTH + 1);

  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(RAS_ENTRIES);
  localparam logic [CK_NUM_W-1:0] CK_MAX  = CK_NUM_W'(CKPT_DEPTH);
  localparam logic [CK_PTR_W-1:0] CK_LAST = CK_PTR_W'(CKPT_DEPTH - 1);

  logic [ADDR_W-1:0]      mem [RAS_ENTRIES];
  logic [RAS_DEPTH_W-1:0] read_index;
  logic [CNT_W-1:0]       count;

  logic [RAS_DEPTH_W-1:0] ck_idx [CKPT_DEPTH];
  logic [CNT_W-1:0]       ck_cnt [CKPT_DEPTH];
`ifdef RAS_TOS_REPAIR_EN
  logic [ADDR_W-1:0]      ck_tos [CKPT_DEPTH];
`endif
  logic [CK_PTR_W-1:0]    ck_wr;
  logic [CK_PTR_W-1:0]    ck_rd;
  logic [CK_NUM_W-1:0]    ck_num;

  // Index arithmetic wraps: on overflow the oldest entry is silently reused.
  function automatic logic [RAS_DEPTH_W-1:0] wrap_index(
    input logic [RAS_DEPTH_W-1:0] b, input logic inc, input logic dec);
    logic [RAS_DEPTH_W-1:0] r;
    r = b;
    if (inc && !dec)      r = b + 1'b1;
    else if (dec && !inc) r = b - 1'b1;
    return r;
  endfunction

  // Occupancy saturates at 0 and RAS_ENTRIES; computed one bit wider.
  function automatic logic [CNT_W-1:0] sat_count(
    input logic [CNT_W-1:0] c, input logic inc, input logic dec);
    logic [CNT_W:0] w;
    w = {1'b0, c};
    if (inc && !dec)      w = (c == CNT_MAX) ? w : w + 1'b1;
    else if (dec && !inc) w = (c == '0) ? w : w - 1'b1;
    return w[CNT_W-1:0];
  endfunction

  function automatic logic [CK_PTR_W-1:0] ck_next(input logic [CK_PTR_W-1:0] p);
    return (p == CK_LAST) ? '0 : p + 1'b1;
  endfunction

  logic                   ck_empty;
  logic                   flush_any;
  logic                   restore;
  logic                   ck_enq;
  logic                   ck_deq;
  logic [RAS_DEPTH_W-1:0] base_idx;
  logic [CNT_W-1:0]       base_cnt;
  logic [RAS_DEPTH_W-1:0] new_index;
  logic [CNT_W-1:0]       new_count;

  assign ck_empty  = (ck_num == '0);
  assign flush_any = fetch_flush | early_flush;
  assign restore   = fetch_flush & ~ck_empty;
  // A branch fetched during a flush belongs to the squashed path.
  assign ck_enq    = branch_fetched & ~flush_any & ~ckpt_full;
  assign ck_deq    = branch_retired & ~flush_any & ~ck_empty;

  assign base_idx  = restore ? ck_idx[ck_rd] : read_index;
  assign base_cnt  = restore ? ck_cnt[ck_rd] : count;
  assign new_index = wrap_index(base_idx, push, pop);
  assign new_count = sat_count(base_cnt, push, pop);

  assign addr       = mem[read_index];
  assign addr_valid = (count != '0);
  assign ckpt_full  = (ck_num == CK_MAX);

  // Stage p0 -> registered state: stack memory write port (push beats repair)
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push) begin
        mem[new_index] <= new_addr;
      end
`ifdef RAS_TOS_REPAIR_EN
      else if (restore) begin
        mem[base_idx] <= ck_tos[ck_rd];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ck_enq) begin
      ck_idx[ck_wr] <= read_index;
      ck_cnt[ck_wr] <= count;
`ifdef RAS_TOS_REPAIR_EN
      ck_tos[ck_wr] <= addr;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_index <= '0;
      count      <= '0;
      ck_wr      <= '0;
      ck_rd      <= '0;
      ck_num     <= '0;
    end else begin
      read_index <= new_index;
      count      <= new_count;
      if (flush_any) begin
        ck_wr  <= '0;
        ck_rd  <= '0;
        ck_num <= '0;
      end else begin
        if (ck_enq) ck_wr <= ck_next(ck_wr);
        if (ck_deq) ck_rd <= ck_next(ck_rd);
        if (ck_enq && !ck_deq)      ck_num <= ck_num + 1'b1;
        else if (ck_deq && !ck_enq) ck_num <= ck_num - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ras_checkpointed.sv
module tb_ras_checkpointed;

  localparam int N  = 8;
  localparam int AW = 32;
  localparam int CK = 8;
`ifdef RAS_TOS_REPAIR_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, fetch_flush, early_flush, branch_fetched, branch_retired;
  logic          push, pop;
  logic [AW-1:0] new_addr;
  logic [AW-1:0] addr;
  logic          addr_valid, ckpt_full;

  ras_checkpointed #(.RAS_ENTRIES(N), .ADDR_W(AW), .CKPT_DEPTH(CK)) dut (
    .clk(clk), .rst(rst), .fetch_flush(fetch_flush), .early_flush(early_flush),
    .branch_fetched(branch_fetched), .branch_retired(branch_retired),
    .push(push), .pop(pop), .new_addr(new_addr),
    .addr(addr), .addr_valid(addr_valid), .ckpt_full(ckpt_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, ff, ef, bf, br, push, pop;
    logic [AW-1:0] na;
    logic          e_valid;
    logic [AW-1:0] e_addr;
    logic          e_full;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: a stack addressed modulo N, a saturating occupancy and a
  // queue of snapshots.
  typedef struct { int idx; int cnt; logic [AW-1:0] tos; } snap_t;
  logic [AW-1:0] m_mem [N];
  int            m_idx = 0;
  int            m_cnt = 0;
  snap_t         m_q[$];

  task automatic m_step(input vec_t v);
    int    bi, bc, ni, nc, sz;
    snap_t s;
    if (v.rst) begin
      m_idx = 0; m_cnt = 0; m_q.delete();
      return;
    end
    sz = m_q.size();
    bi = m_idx; bc = m_cnt;
    if (v.ff && sz > 0) begin bi = m_q[0].idx; bc = m_q[0].cnt; end
    ni = (bi + int'(v.push) - int'(v.pop) + N) % N;
    nc = bc + int'(v.push) - int'(v.pop);
    if (nc < 0) nc = 0;
    if (nc > N) nc = N;
    s.idx = m_idx; s.cnt = m_cnt; s.tos = m_mem[m_idx];
    if (v.push) m_mem[ni] = v.na;
    else if (REP && v.ff && sz > 0) m_mem[bi] = m_q[0].tos;
    if (v.ff || v.ef) m_q.delete();
    else begin
      if (v.br && sz > 0) void'(m_q.pop_front());
      if (v.bf && sz < CK) m_q.push_back(s);
    end
    m_idx = ni; m_cnt = nc;
  endtask

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; fetch_flush = v.ff; early_flush = v.ef;
    branch_fetched = v.bf; branch_retired = v.br;
    push = v.push; pop = v.pop; new_addr = v.na;
    m_step(v);
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, ff, ef, bf, br, pu, po,
                              input logic [AW-1:0] na, input logic ev,
                              input logic [AW-1:0] ea, input logic efull);
    vec_t v;
    v.rst = r; v.ff = ff; v.ef = ef; v.bf = bf; v.br = br;
    v.push = pu; v.pop = po; v.na = na;
    v.e_valid = ev; v.e_addr = ea; v.e_full = efull;
    vecs.push_back(v);
  endfunction

  initial begin
    vec_t v;
    rst = 1'b1; fetch_flush = 0; early_flush = 0; branch_fetched = 0;
    branch_retired = 0; push = 0; pop = 0; new_addr = '0;
    for (int i = 0; i < N; i++) m_mem[i] = '0;

    // basic push/pop
    add(1,0,0,0,0,0,0, 0,     0, 0,     0);
    add(0,0,0,0,0,1,0, 'h100, 1, 'h100, 0);
    add(0,0,0,0,0,1,0, 'h200, 1, 'h200, 0);
    add(0,0,0,0,0,0,1, 0,     1, 'h100, 0);
    add(0,0,0,0,0,0,1, 0,     0, 0,     0);
    // overflow: nine pushes into eight entries
    add(1,0,0,0,0,0,0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) add(0,0,0,0,0,1,0, k*'h10, 1, k*'h10, 0);
    for (int j = 1; j <= 7; j++) add(0,0,0,0,0,0,1, 0, 1, (9-j)*'h10, 0);
    add(0,0,0,0,0,0,1, 0, 0, 0, 0);
    // restore after wrong-path push/pop, no overwrite
    add(1,0,0,0,0,0,0, 0,    0, 0,    0);
    add(0,0,0,0,0,1,0, 'hA0, 1, 'hA0, 0);
    add(0,0,0,1,0,0,0, 0,    1, 'hA0, 0);
    add(0,0,0,0,0,1,0, 'hB0, 1, 'hB0, 0);
    add(0,0,0,0,0,0,1, 0,    1, 'hA0, 0);
    add(0,0,0,0,0,0,1, 0,    0, 0,    0);
    add(1'b0,1'b1,0,0,0,0,0, 0, 1, 'hA0, 0);
    // restore after wrong-path overwrite of the top slot
    add(1,0,0,0,0,0,0, 0,    0, 0,    0);
    add(0,0,0,0,0,1,0, 'hA0, 1, 'hA0, 0);
    add(0,0,0,1,0,0,0, 0,    1, 'hA0, 0);
    add(0,0,0,0,0,0,1, 0,    0, 0,    0);
    add(0,0,0,0,0,1,0, 'hC0, 1, 'hC0, 0);
    add(0,1,0,0,0,0,0, 0,    1, REP ? 'hA0 : 'hC0, 0);
    // checkpoint store capacity
    add(1,0,0,0,0,0,0, 0, 0, 0, 0);
    for (int k = 1; k <= CK; k++) add(0,0,0,1,0,0,0, 0, 0, 0, (k == CK));
    add(0,0,0,1,0,0,0, 0, 0, 0, 1);
    add(0,0,0,0,1,0,0, 0, 0, 0, 0);
    add(0,0,0,1,0,0,0, 0, 0, 0, 1);
    add(0,0,1,0,0,0,0, 0, 0, 0, 0);
    // early flush then stray retire and flush on empty store
    add(1,0,0,0,0,0,0, 0,    0, 0,    0);
    add(0,0,0,0,0,1,0, 'h11, 1, 'h11, 0);
    for (int k = 0; k < 3; k++) add(0,0,0,1,0,0,0, 0, 1, 'h11, 0);
    add(0,0,1,0,0,0,0, 0,    1, 'h11, 0);
    add(0,0,0,0,1,0,0, 0,    1, 'h11, 0);
    add(0,0,0,0,0,1,0, 'h22, 1, 'h22, 0);
    add(0,1,0,0,0,0,0, 0,    1, 'h22, 0);
    for (int k = 1; k <= CK; k++) add(0,0,0,1,0,0,0, 0, 1, 'h22, (k == CK));
    // push and pop together
    add(1,0,0,0,0,0,0, 0,    0, 0,    0);
    add(0,0,0,0,0,1,1, 'h77, 0, 0,    0);
    add(0,0,0,0,0,1,0, 'h33, 1, 'h33, 0);
    add(0,0,0,0,0,0,1, 0,    0, 0,    0);
    add(1,0,0,0,0,0,0, 0,    0, 0,    0);
    for (int k = 1; k <= N; k++) add(0,0,0,0,0,1,0, k, 1, k, 0);
    add(0,0,0,0,0,1,1, 'h77, 1, 'h77, 0);
    add(0,0,0,0,0,0,1, 0,    1, N-1,  0);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      chk($sformatf("row%0d.valid", i), {31'b0, addr_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("row%0d.full", i), {31'b0, ckpt_full}, {31'b0, vecs[i].e_full});
      if (vecs[i].e_valid) chk($sformatf("row%0d.addr", i), addr, vecs[i].e_addr);
    end

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      v.rst  = ($urandom_range(199) == 0);
      v.ff   = ($urandom_range(15) == 0);
      v.ef   = ($urandom_range(31) == 0);
      v.bf   = ($urandom_range(3) == 0);
      v.br   = ($urandom_range(3) == 0);
      v.push = ($urandom_range(2) == 0);
      v.pop  = ($urandom_range(2) == 0);
      v.na   = $urandom;
      v.e_valid = 1'b0; v.e_addr = '0; v.e_full = 1'b0;
      apply(v);
      chk($sformatf("rnd%0d.valid", c), {31'b0, addr_valid}, {31'b0, (m_cnt != 0)});
      chk($sformatf("rnd%0d.full", c), {31'b0, ckpt_full}, {31'b0, (m_q.size() == CK)});
      if (m_cnt != 0) chk($sformatf("rnd%0d.addr", c), addr, m_mem[m_idx]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
